// File: rtl/shader_pkg.sv
// shader_pkg: shared definitions for shader_core, shader_instr_sequencer and
// their benches. Instruction word layout, opcode values, control-nibble bit
// positions and the sequencer state encoding.
package shader_pkg;

  localparam int INSTR_W = 16;

  // opcodes, instr[15:13]
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  // field bit positions
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int RS1_HI  = 12;
  localparam int RS1_LO  = 10;
  localparam int RS2_HI  = 9;
  localparam int RS2_LO  = 7;
  localparam int RD_HI   = 6;
  localparam int RD_LO   = 4;
  localparam int CTRL_HI = 3;
  localparam int CTRL_LO = 0;

  // register write enable inside the control nibble
  localparam int CTRL_WE_BIT = 0;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/shader_prog_ram.sv
// shader_prog_ram: DEPTH x 16 program store.
//   clk    - write clock
//   we     - write enable
//   waddr  - write slot
//   wdata  - write word
//   raddr  - asynchronous read slot
//   rdata  - word at raddr
// Contents are never reset.
module shader_prog_ram
  import shader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/shader_instr_sequencer.sv
// shader_instr_sequencer: issues a loaded program to shader_core, one word per
// clock, after a start pulse.
//   clk, rst            - clock, synchronous active-high reset
//   load_en/addr/data   - program write port (IDLE only)
//   prog_len            - instructions to issue, clamped to DEPTH, taken at start
//   start               - begin issuing from slot 0 (IDLE only)
//   abort               - stop issuing next cycle (ISSUE only), no done
//   loop                - only with SHADER_SEQ_LOOP_EN: rerun from slot 0 on wrap
//   instr/instr_valid   - registered instruction to the core
//   pc                  - slot currently on instr
//   busy                - in ISSUE
//   done                - one-cycle completion pulse
// Build option: SHADER_SEQ_LOOP_EN adds the loop input.
module shader_instr_sequencer
  import shader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               abort,
`ifdef SHADER_SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               mem_we, wrap;
  logic [INSTR_W-1:0] rd_data;
  logic [ADDR_W:0]    len_clamp;
  logic               last;

  assign mem_we    = load_en && (state_q == SEQ_IDLE);
  assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last      = ({1'b0, pc_q} == (len_q - ONE_L));

`ifdef SHADER_SEQ_LOOP_EN
  assign wrap = loop;
`else
  assign wrap = 1'b0;
`endif

  // Read port is addressed by the next pc so instr can be registered.
  shader_prog_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_d),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        pc_d = '0;
        if (start) begin
          len_d = len_clamp;
          if (len_clamp == '0) begin
            state_d = SEQ_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEQ_ISSUE;
            vld_d   = 1'b1;
          end
        end
      end
      SEQ_ISSUE: begin
        if (abort) begin
          state_d = SEQ_IDLE;
          pc_d    = '0;
        end else if (last) begin
          pc_d = '0;
          if (wrap) begin
            vld_d = 1'b1;
          end else begin
            state_d = SEQ_DONE;
            done_d  = 1'b1;
          end
        end else begin
          pc_d  = pc_q + PC_ONE;
          vld_d = 1'b1;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
        pc_d    = '0;
      end
      default: begin
        state_d = SEQ_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // A write landing on the same edge as start must be seen by slot 0, but the
  // array only updates at that edge, so forward the incoming word.
  always_comb begin
    instr_d = '0;
    if (vld_d) begin
      instr_d = (mem_we && (load_addr == pc_d)) ? load_data : rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign busy        = (state_q == SEQ_ISSUE);
  assign done        = done_q;

endmodule

// File: tb/tb_shader_instr_sequencer.sv
// Bench for shader_instr_sequencer (default build, no loop port). A reference
// program array tracks what should be in the sequencer; each run's expected
// cycle-by-cycle output is derived from the issue rules directly.
module tb_shader_instr_sequencer;
  import shader_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, load_en, start, abort;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [AW:0]   prog_len;
  logic [15:0]   instr;
  logic          instr_valid, busy, done;
  logic [AW-1:0] pc;

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  shader_instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .abort(abort),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [15:0] e_instr, input logic e_v,
                             input int e_pc, input logic e_busy, input logic e_done,
                             input bit pc_chk);
    chk({tag, ".instr"}, 32'(instr), 32'(e_instr));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_v));
    if (pc_chk) chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic exp_idle(input string tag);
    check_cycle(tag, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  // All tasks enter and leave at a negedge; inputs set here hit the next posedge.
  task automatic load(input int addr, input logic [15:0] data);
    load_en = 1'b1; load_addr = AW'(addr); load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  // stop_at: slot during which abort (stop_kind 0) or rst (1) is raised, -1 none.
  // noise_at: slot during which a stray load to slot 0 and a second start occur.
  // new0: load slot 0 with w0 on the same edge as start.
  task automatic run(input string tag, input int len_req, input int stop_at, input int stop_kind,
                     input int noise_at, input bit new0, input logic [15:0] w0);
    int len;
    len = (len_req > DEPTH) ? DEPTH : len_req;
    start = 1'b1; prog_len = (AW+1)'(len_req);
    if (new0) begin
      load_en = 1'b1; load_addr = '0; load_data = w0;
      ref_mem[0] = w0;
    end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    for (int k = 0; k < len; k++) begin
      check_cycle({tag, ".issue"}, ref_mem[k], 1'b1, k, 1'b1, 1'b0, 1'b1);
      if (k == stop_at) begin
        if (stop_kind == 0) abort = 1'b1; else rst = 1'b1;
        @(negedge clk);
        abort = 1'b0; rst = 1'b0;
        exp_idle({tag, ".stopped"});
        @(negedge clk);
        exp_idle({tag, ".stopped2"});
        return;
      end
      if (k == noise_at) begin
        load_en = 1'b1; load_addr = '0; load_data = 16'hFFFF;
        start = 1'b1; prog_len = (AW+1)'($urandom_range(1, DEPTH));
      end
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
    end
    check_cycle({tag, ".done"}, 16'h0000, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    exp_idle({tag, ".post"});
  endtask

  initial begin
    int len, stop_at, noise_at;
    rst = 1'b1; load_en = 1'b0; start = 1'b0; abort = 1'b0;
    load_addr = '0; load_data = '0; prog_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_idle("reset");

    // fill every slot so later runs never read uninitialised words
    for (int i = 0; i < DEPTH; i++) load(i, 16'($urandom));
    exp_idle("after_load");

    load(0, 16'h01F1);
    load(1, 16'h29F1);
    run("single", 2, -1, 0, -1, 1'b0, 16'h0);
    run("zero", 0, -1, 0, -1, 1'b0, 16'h0);
    run("clamp", DEPTH + 1, -1, 0, -1, 1'b0, 16'h0);
    run("noise", 8, -1, 0, 2, 1'b0, 16'h0);
    run("noise_rerun", 8, -1, 0, -1, 1'b0, 16'h0);
    run("noise_last", 3, -1, 0, 2, 1'b0, 16'h0);
    run("abort", 8, 3, 0, -1, 1'b0, 16'h0);
    run("reset_mid", 8, 5, 1, -1, 1'b0, 16'h0);
    run("reset_rerun", 8, -1, 0, -1, 1'b0, 16'h0);
    run("ld_start", 4, -1, 0, -1, 1'b1, 16'hA5C3);
    // abort outside ISSUE has no effect
    abort = 1'b1;
    @(negedge clk);
    exp_idle("abort_idle");
    run("abort_held", 0, -1, 0, -1, 1'b0, 16'h0);
    abort = 1'b0;

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, DEPTH - 1), 16'($urandom));
      len = $urandom_range(0, DEPTH + 1);
      stop_at = -1; noise_at = -1;
      if (len > 0 && $urandom_range(0, 3) == 0)
        stop_at = $urandom_range(0, ((len > DEPTH) ? DEPTH : len) - 1);
      if (len > 0 && $urandom_range(0, 3) == 0)
        noise_at = $urandom_range(0, ((len > DEPTH) ? DEPTH : len) - 1);
      run("rand", len, stop_at, $urandom_range(0, 1), noise_at,
          1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
